// File: rtl/dm_bus_access.sv
// ============================================================================
// dm_bus_access : MEM-stage load/store controller running a req/ack bus cycle
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_bus_access #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        we,
    input  logic [3:0]  BE,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_type,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        addr_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              addr_err_q, addr_err_d;
    logic              bus_err_q, bus_err_d;
    logic [2:0]        ld_type_q, ld_type_d;
    logic [1:0]        off_q, off_d;
    logic              misaligned, start, stall_c;

    // Lane extraction uses the byte offset latched at the start of the access.
    function automatic logic [31:0] extend(input logic [2:0] lt, input logic [1:0] off,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (lt)
            3'd1:    extend = {{16{h[15]}}, h};
            3'd2:    extend = {16'h0000, h};
            3'd3:    extend = {{24{b[7]}}, b};
            3'd4:    extend = {24'h000000, b};
            default: extend = w;
        endcase
    endfunction

    always_comb begin
        misaligned = 1'b0;
        if (!we) begin
            case (ld_type)
                3'd1, 3'd2: misaligned = addr[0];
                3'd3, 3'd4: misaligned = 1'b0;
                default:    misaligned = (addr[1:0] != 2'b00);
            endcase
        end
        start = mem_en && !(we && (BE == 4'b0000)) && !misaligned;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        ld_type_d   = ld_type_q;
        off_d       = off_q;
        done_d      = 1'b0;
        addr_err_d  = 1'b0;
        bus_err_d   = 1'b0;
        stall_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = REQ;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = we;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = we ? BE : 4'b1111;
                    bus_wdata_d = wdata;
                    ld_type_d   = ld_type;
                    off_d       = addr[1:0];
                    stall_c     = 1'b1;
                end else if (mem_en && misaligned) begin
                    addr_err_d = 1'b1;
                end
            end
            REQ: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                // An ack arriving on the final allowed cycle still completes normally.
                if (bus_ack) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    rdata_d   = bus_we_q ? 32'h0 : extend(ld_type_q, off_q, bus_rdata);
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                    rdata_d   = 32'h0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
            addr_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            ld_type_q   <= 3'h0;
            off_q       <= 2'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            addr_err_q  <= addr_err_d;
            bus_err_q   <= bus_err_d;
            ld_type_q   <= ld_type_d;
            off_q       <= off_d;
        end
    end

    assign stall     = stall_c && !reset;
    assign rdata     = rdata_q;
    assign done      = done_q;
    assign addr_err  = addr_err_q;
    assign bus_err   = bus_err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_bus_access.sv
// ============================================================================
// tb_dm_bus_access : directed self-checking bench for dm_bus_access
// Revision         : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dm_bus_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_en, we, bus_ack;
    logic [3:0]  BE;
    logic [31:0] addr, wdata, bus_rdata;
    logic [2:0]  ld_type;
    logic        stall, done, addr_err, bus_err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dm_bus_access #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .mem_en(mem_en), .we(we), .BE(BE),
        .addr(addr), .wdata(wdata), .ld_type(ld_type), .stall(stall),
        .rdata(rdata), .done(done), .addr_err(addr_err), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        mem_en = 1'b0; we = 1'b0; BE = 4'h0; addr = 32'h0; wdata = 32'h0;
        ld_type = 3'd0; bus_ack = 1'b0; bus_rdata = 32'h0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one access; ack_at is the 1-based REQ cycle carrying bus_ack (0 = never).
    task automatic access(input logic w, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] lt, input int ack_at,
                          input logic [31:0] brd, output int stalls, output int reqs,
                          output logic [31:0] rd, output logic berr, output logic [31:0] baddr,
                          output logic [3:0] bbe, output logic bwe, output logic seen_done);
        mem_en = 1'b1; we = w; BE = be; addr = a; wdata = wd; ld_type = lt;
        bus_rdata = brd;
        stalls = 0; reqs = 0; seen_done = 1'b0; rd = 'x; berr = 'x;
        baddr = 'x; bbe = 'x; bwe = 'x;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            #1;
            if (stall) stalls++;
            if (bus_req) begin
                reqs++;
                if (reqs == 1) begin
                    baddr = bus_addr; bbe = bus_be; bwe = bus_we;
                end
            end
            bus_ack = bus_req && (reqs == ack_at);
            if (done) begin
                seen_done = 1'b1; rd = rdata; berr = bus_err; mem_en = 1'b0;
            end
            cyc();
            bus_ack = 1'b0;
        end
        chk("access_done_seen", 32'(seen_done), 32'd1);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    int          st, rq;
    logic [31:0] rd, ba;
    logic [3:0]  bb;
    logic        be_, bw, sd;

    initial begin
        drive_idle();
        reset = 1'b1;
        mem_en = 1'b1; we = 1'b1; BE = 4'hF; addr = 32'h1004;
        cyc(); cyc();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        drive_idle();
        reset = 1'b0;
        cyc();

        // SW, immediate ack
        access(1'b1, 4'hF, 32'h0000_1004, 32'hDEADBEEF, 3'd0, 1, 32'h0,
               st, rq, rd, be_, ba, bb, bw, sd);
        chk("sw_bus_addr", ba, 32'h0000_1004);
        chk("sw_bus_be", 32'(bb), 32'hF);
        chk("sw_bus_we", 32'(bw), 32'd1);
        chk("sw_stall_cycles", st, 32'd2);
        chk("sw_req_cycles", rq, 32'd1);
        chk("sw_bus_err", 32'(be_), 32'd0);

        // SB, ack 3 cycles after bus_req rises
        access(1'b1, 4'b0100, 32'h0000_1006, 32'h00AB_0000, 3'd0, 4, 32'h0,
               st, rq, rd, be_, ba, bb, bw, sd);
        chk("sb_bus_addr", ba, 32'h0000_1004);
        chk("sb_bus_be", 32'(bb), 32'b0100);
        chk("sb_req_cycles", rq, 32'd4);
        chk("sb_stall_cycles", st, 32'd5);

        // Byte loads
        access(1'b0, 4'h0, 32'h0000_2003, 32'h0, 3'd3, 1, 32'h8012_3456,
               st, rq, rd, be_, ba, bb, bw, sd);
        chk("lb_rdata", rd, 32'hFFFF_FF80);
        chk("lb_bus_be", 32'(bb), 32'hF);
        chk("lb_bus_we", 32'(bw), 32'd0);
        chk("lb_bus_addr", ba, 32'h0000_2000);
        chk("rdata_hold", rdata, 32'hFFFF_FF80);
        access(1'b0, 4'h0, 32'h0000_2003, 32'h0, 3'd4, 2, 32'h8012_3456,
               st, rq, rd, be_, ba, bb, bw, sd);
        chk("lbu_rdata", rd, 32'h0000_0080);
        access(1'b0, 4'h0, 32'h0000_2001, 32'h0, 3'd3, 1, 32'h8012_3456,
               st, rq, rd, be_, ba, bb, bw, sd);
        chk("lb_lane1_rdata", rd, 32'h0000_0034);

        // Half and word loads
        access(1'b0, 4'h0, 32'h0000_2002, 32'h0, 3'd1, 1, 32'h9ABC_1234,
               st, rq, rd, be_, ba, bb, bw, sd);
        chk("lh_rdata", rd, 32'hFFFF_9ABC);
        access(1'b0, 4'h0, 32'h0000_2002, 32'h0, 3'd2, 1, 32'h9ABC_1234,
               st, rq, rd, be_, ba, bb, bw, sd);
        chk("lhu_rdata", rd, 32'h0000_9ABC);
        access(1'b0, 4'h0, 32'h0000_2000, 32'h0, 3'd1, 1, 32'h9ABC_1234,
               st, rq, rd, be_, ba, bb, bw, sd);
        chk("lh_low_rdata", rd, 32'h0000_1234);
        access(1'b0, 4'h0, 32'h0000_2000, 32'h0, 3'd0, 1, 32'h9ABC_1234,
               st, rq, rd, be_, ba, bb, bw, sd);
        chk("lw_rdata", rd, 32'h9ABC_1234);

        // Misaligned LW: addr_err, no bus cycle, no stall
        mem_en = 1'b1; we = 1'b0; ld_type = 3'd0; addr = 32'h0000_2002;
        #1;
        chk("mis_stall", 32'(stall), 32'd0);
        cyc();
        mem_en = 1'b0;
        chk("mis_addr_err", 32'(addr_err), 32'd1);
        chk("mis_bus_req", 32'(bus_req), 32'd0);
        cyc();
        chk("mis_addr_err_clr", 32'(addr_err), 32'd0);
        chk("mis_bus_req2", 32'(bus_req), 32'd0);

        // Store with no byte enables is a no-op
        mem_en = 1'b1; we = 1'b1; BE = 4'h0; addr = 32'h0000_3000;
        #1;
        chk("be0_stall", 32'(stall), 32'd0);
        cyc();
        mem_en = 1'b0;
        chk("be0_bus_req", 32'(bus_req), 32'd0);
        chk("be0_done", 32'(done), 32'd0);
        cyc();

        // Timeout with no ack
        access(1'b0, 4'h0, 32'h0000_4000, 32'h0, 3'd0, 0, 32'h1234_5678,
               st, rq, rd, be_, ba, bb, bw, sd);
        chk("to_req_cycles", rq, 32'd15);
        chk("to_bus_err", 32'(be_), 32'd1);
        chk("to_rdata", rd, 32'h0);
        chk("to_bus_err_clr", 32'(bus_err), 32'd0);
        // Ack on the last allowed REQ cycle wins over the timeout
        access(1'b0, 4'h0, 32'h0000_4000, 32'h0, 3'd0, 15, 32'h1234_5678,
               st, rq, rd, be_, ba, bb, bw, sd);
        chk("to_ack_req_cycles", rq, 32'd15);
        chk("to_ack_bus_err", 32'(be_), 32'd0);
        chk("to_ack_rdata", rd, 32'h1234_5678);

        // Reset asserted mid-REQ abandons the transaction
        mem_en = 1'b1; we = 1'b1; BE = 4'hF; addr = 32'h0000_5000; wdata = 32'h1;
        cyc();
        chk("rr_bus_req_before", 32'(bus_req), 32'd1);
        reset = 1'b1; mem_en = 1'b0;
        #1;
        chk("rr_stall_in_reset", 32'(stall), 32'd0);
        cyc();
        reset = 1'b0;
        chk("rr_bus_req_after", 32'(bus_req), 32'd0);
        chk("rr_done_after", 32'(done), 32'd0);
        cyc();
        bus_ack = 1'b1;
        #1;
        chk("rr_stall_late_ack", 32'(stall), 32'd0);
        cyc();
        bus_ack = 1'b0;
        chk("rr_no_done", 32'(done), 32'd0);
        chk("rr_no_bus_err", 32'(bus_err), 32'd0);
        chk("rr_bus_req_idle", 32'(bus_req), 32'd0);
        access(1'b0, 4'h0, 32'h0000_6000, 32'h0, 3'd4, 1, 32'h0000_00F1,
               st, rq, rd, be_, ba, bb, bw, sd);
        chk("rr_next_rdata", rd, 32'h0000_00F1);
        chk("rr_next_stalls", st, 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dm_bus_access.md
Name: dm_bus_access

Overview:
- Memory-stage access controller sitting directly downstream of the store byte-enable decoder.
- Consumes the MEM-stage request (address, write data, 4-bit BE, load type) and runs a multi-cycle req/ack transaction on the system bus.
- Stalls the pipeline while the transaction is outstanding and returns sign- or zero-extended load data to writeback.

Parameters:
- TIMEOUT, 15: max cycles in REQ without bus_ack before the access is aborted with bus_err.
- CNT_W, 4: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_en  input  1  MEM stage holds a memory instruction.
- we  input  1  1 = store, 0 = load.
- BE  input  4  store byte enables from upstream decoder.
- addr  input  32  byte address.
- wdata  input  32  store data, already lane-aligned.
- ld_type  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5–7 treated as LW.
- stall  output  1  freeze PC/IF/ID/EX/MEM.
- rdata  output  32  extended load result.
- done  output  1  one-cycle pulse: access complete, rdata/bus_err valid.
- addr_err  output  1  one-cycle pulse: misaligned load, no bus cycle issued.
- bus_err  output  1  one-cycle pulse with done: transaction timed out.
- bus_req  output  1  bus request, registered.
- bus_we  output  1  bus write strobe.
- bus_addr  output  32  word address: {addr[31:2],2'b00}.
- bus_be  output  4  byte enables; 4'b1111 for loads.
- bus_wdata  output  32  write data.
- bus_ack  input  1  bus completion, sampled on clk.
- bus_rdata  input  32  raw word, valid with bus_ack.

Behaviour:
- Reset:
  - State goes to IDLE, counter to 0.
  - All registered outputs are 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, done, addr_err, bus_err.
  - stall is forced to 0 while reset is high.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Start condition: mem_en && !(we && BE==0) && !misaligned.
  - Misaligned means a load with LW and addr[1:0]!=0, or LH/LHU and addr[0]==1.
  - On start: latch addr/BE/wdata/we/ld_type and load the bus outputs; next state is REQ with bus_req=1 and counter=0.
  - stall is combinationally 1 in the start cycle.
  - Misaligned load: addr_err pulses next cycle, no stall, state stays IDLE.
  - Store with BE==0: no-op, no stall.
- REQ:
  - stall=1; bus outputs held stable.
  - Counter increments each cycle.
  - bus_ack high: next state DONE; register rdata = extend(bus_rdata) for loads, 0 for stores; bus_req drops to 0.
  - No ack and counter==TIMEOUT-1: next state DONE, bus_err=1, rdata=0, bus_req=0.
  - bus_ack in the same cycle as the timeout condition: ack wins, no bus_err.
- DONE:
  - stall=0 and done=1 for exactly one cycle; the pipeline advances at this edge.
  - mem_en is ignored (it is still the completed instruction).
  - Next state is always IDLE; bus_err clears.
- Minimum access latency: start cycle, REQ with immediate ack, DONE. That is 2 stall cycles, and done appears 2 cycles after the start cycle.
- Load extraction, using latched addr[1:0]:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes the word through.
- bus_ack outside REQ is ignored.
- Reset asserted in REQ: bus_req is 0 after that edge, the transaction is abandoned, no done pulse, and any later ack is ignored.
- rdata holds its last value until the next DONE.

Test Plan:
- SW: addr=0x0000_1004, BE=1111, wdata=0xDEADBEEF, ack in first REQ cycle -> bus_addr=0x1004, bus_be=1111, bus_we=1; stall high 2 cycles; done pulses once.
- SB: addr=0x1006, BE=0100, ack 3 cycles after bus_req -> bus_addr=0x1004, bus_be=0100, bus_req high 4 cycles, stall high 5 cycles.
- LB: addr=0x2003, bus_rdata=0x80123456 -> rdata=0xFFFFFF80; LBU on the same data -> 0x00000080.
- LH: addr=0x2002, bus_rdata=0x9ABC1234 -> rdata=0xFFFF9ABC; LHU -> 0x00009ABC; LW at 0x2002 -> addr_err pulse, bus_req never asserted, no stall.
- Timeout: no ack, TIMEOUT=15 -> bus_req high 15 cycles, then done=1, bus_err=1, rdata=0; repeat with ack on the 15th REQ cycle -> bus_err=0.
- Reset mid-REQ: reset for 1 cycle during REQ, ack 2 cycles later -> bus_req=0 after reset edge, no done, stall=0, next request proceeds normally.
